// File: rtl/bullet_scheduler_if.sv
// Spawn request and bullet-table write bus between a producer/consumer (master)
// and the bullet scheduler (slave).
interface bullet_scheduler_if;
  logic        spawn_valid;
  logic        spawn_ready;
  logic [7:0]  spawn_x;
  logic [7:0]  spawn_y;
  logic [3:0]  spawn_dx;
  logic [3:0]  spawn_dy;
  logic [7:0]  spawn_w;
  logic [7:0]  spawn_h;
  logic [2:0]  spawn_color;

  logic        wr_en;
  logic [2:0]  wr_index;
  logic [15:0] wr_position;
  logic [15:0] wr_size;
  logic [2:0]  wr_color;
  logic        wr_render;

  modport master (
    output spawn_valid, spawn_x, spawn_y, spawn_dx, spawn_dy, spawn_w, spawn_h, spawn_color,
    input  spawn_ready, wr_en, wr_index, wr_position, wr_size, wr_color, wr_render
  );

  modport slave (
    input  spawn_valid, spawn_x, spawn_y, spawn_dx, spawn_dy, spawn_w, spawn_h, spawn_color,
    output spawn_ready, wr_en, wr_index, wr_position, wr_size, wr_color, wr_render
  );
endinterface

// File: rtl/bullet_scheduler.sv
// Eight-slot bullet scheduler: clears the bullet table, accepts spawns into the
// lowest free slot and sweeps every live slot once per frame tick.
module bullet_slot_move (
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [3:0]  dx,
  input  logic [3:0]  dy,
  output logic [15:0] pos,
  output logic        exits
);
  logic [8:0] nx, ny;

  // 9-bit sum: bit 8 flags leaving the 0..255 field on either side
  assign nx    = {1'b0, x} + {{5{dx[3]}}, dx};
  assign ny    = {1'b0, y} + {{5{dy[3]}}, dy};
  assign exits = nx[8] | ny[8];
  assign pos   = {nx[7:0], ny[7:0]};
endmodule

module bullet_scheduler (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_tick,
  bullet_scheduler_if.slave         bus,
  output logic                      busy,
  output logic [3:0]                active_count,
  output logic                      update_done,
  output logic                      tick_overrun
);
  localparam int NUM_SLOTS = 8;

  typedef enum logic [1:0] {CLEAR, IDLE, UPDATE} state_t;

  typedef struct packed {
    logic       active;
    logic [7:0] x;
    logic [7:0] y;
    logic [3:0] dx;
    logic [3:0] dy;
    logic [7:0] w;
    logic [7:0] h;
    logic [2:0] color;
  } slot_t;

  typedef struct packed {
    logic        en;
    logic [2:0]  index;
    logic [15:0] position;
    logic [15:0] size;
    logic [2:0]  color;
    logic        render;
  } wr_t;

  state_t                          state, state_nxt;
  logic [2:0]                      cnt, cnt_nxt;
  logic                            pending, pend_nxt;
  logic                            ovr_nxt;
  logic                            done_nxt;
  slot_t [NUM_SLOTS-1:0]           slots, slots_nxt;
  wr_t                             wr_q, wr_nxt;
  logic [3:0]                      count_nxt;
  logic [NUM_SLOTS-1:0][15:0]      mv_pos;
  logic [NUM_SLOTS-1:0]            mv_exit;
  logic [2:0]                      free_idx;
  logic                            any_free;
  logic                            spawn_ok;
  slot_t                           cur;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_move
    bullet_slot_move u_move (
      .x     (slots[g].x),
      .y     (slots[g].y),
      .dx    (slots[g].dx),
      .dy    (slots[g].dy),
      .pos   (mv_pos[g]),
      .exits (mv_exit[g])
    );
  end

  // Lowest-numbered inactive slot wins
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slots[i].active) begin
        free_idx = 3'(i);
        any_free = 1'b1;
      end
    end
  end

  assign spawn_ok        = (state == IDLE) & ~frame_tick & ~pending & any_free;
  assign bus.spawn_ready = spawn_ok;
  assign busy            = (state != IDLE);
  assign cur             = slots[cnt];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pending;
    ovr_nxt   = tick_overrun;
    done_nxt  = 1'b0;
    slots_nxt = slots;
    wr_nxt    = '0;
    count_nxt = '0;

    // Ticks that land while busy are queued one deep
    if (state != IDLE && frame_tick) begin
      if (pending) ovr_nxt  = 1'b1;
      else         pend_nxt = 1'b1;
    end

    case (state)
      CLEAR: begin
        wr_nxt.en       = 1'b1;
        wr_nxt.index    = cnt;
        slots_nxt[cnt]  = '0;
        cnt_nxt         = cnt + 3'd1;
        if (cnt == 3'd7) state_nxt = IDLE;
      end
      IDLE: begin
        if (frame_tick || pending) begin
          state_nxt = UPDATE;
          cnt_nxt   = '0;
          // a fresh tick alongside a queued one stays queued
          pend_nxt  = frame_tick & pending;
        end else if (bus.spawn_valid && spawn_ok) begin
          slots_nxt[free_idx].active = 1'b1;
          slots_nxt[free_idx].x      = bus.spawn_x;
          slots_nxt[free_idx].y      = bus.spawn_y;
          slots_nxt[free_idx].dx     = bus.spawn_dx;
          slots_nxt[free_idx].dy     = bus.spawn_dy;
          slots_nxt[free_idx].w      = bus.spawn_w;
          slots_nxt[free_idx].h      = bus.spawn_h;
          slots_nxt[free_idx].color  = bus.spawn_color;
          wr_nxt.en       = 1'b1;
          wr_nxt.index    = free_idx;
          wr_nxt.position = {bus.spawn_x, bus.spawn_y};
          wr_nxt.size     = {bus.spawn_w, bus.spawn_h};
          wr_nxt.color    = bus.spawn_color;
          wr_nxt.render   = 1'b1;
        end
      end
      UPDATE: begin
        if (cur.active) begin
          wr_nxt.en    = 1'b1;
          wr_nxt.index = cnt;
          wr_nxt.size  = {cur.w, cur.h};
          wr_nxt.color = cur.color;
          if (mv_exit[cnt]) begin
            slots_nxt[cnt].active = 1'b0;
            wr_nxt.position       = {cur.x, cur.y};
            wr_nxt.render         = 1'b0;
          end else begin
            slots_nxt[cnt].x = mv_pos[cnt][15:8];
            slots_nxt[cnt].y = mv_pos[cnt][7:0];
            wr_nxt.position  = mv_pos[cnt];
            wr_nxt.render    = 1'b1;
          end
        end
        cnt_nxt = cnt + 3'd1;
        if (cnt == 3'd7) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase

    for (int i = 0; i < NUM_SLOTS; i++)
      count_nxt = count_nxt + {3'b0, slots_nxt[i].active};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CLEAR;
      cnt          <= '0;
      pending      <= 1'b0;
      tick_overrun <= 1'b0;
      update_done  <= 1'b0;
      slots        <= '0;
      wr_q         <= '0;
      active_count <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pending      <= pend_nxt;
      tick_overrun <= ovr_nxt;
      update_done  <= done_nxt;
      slots        <= slots_nxt;
      wr_q         <= wr_nxt;
      active_count <= count_nxt;
    end
  end

  assign bus.wr_en       = wr_q.en;
  assign bus.wr_index    = wr_q.index;
  assign bus.wr_position = wr_q.position;
  assign bus.wr_size     = wr_q.size;
  assign bus.wr_color    = wr_q.color;
  assign bus.wr_render   = wr_q.render;
endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler: clear sweep, spawn, motion, edge exit,
// full table, tick overrun and reset mid-sweep.
module tb_bullet_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       busy;
  logic [3:0] active_count;
  logic       update_done;
  logic       tick_overrun;
  int         npass = 0;
  int         ntot  = 0;

  logic        rec_en  [8];
  logic [15:0] rec_pos [8];
  logic        rec_ren [8];

  bullet_scheduler_if bus ();

  bullet_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .bus          (bus),
    .busy         (busy),
    .active_count (active_count),
    .update_done  (update_done),
    .tick_overrun (tick_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got !== exp) $display("FAIL %s: got %0h want %0h", tag, got, exp);
    else npass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spawn(input logic [7:0] x, input logic [7:0] y, input logic [3:0] dx,
                       input logic [3:0] dy, input logic [2:0] c, input int idx, input int cnt);
    int n;
    n = 0;
    bus.spawn_x = x; bus.spawn_y = y; bus.spawn_dx = dx; bus.spawn_dy = dy;
    bus.spawn_w = 8'd4; bus.spawn_h = 8'd4; bus.spawn_color = c;
    while (!bus.spawn_ready && n < 20) begin
      step();
      n++;
    end
    chk("spawn_ready", bus.spawn_ready, 1);
    bus.spawn_valid = 1'b1;
    step();
    bus.spawn_valid = 1'b0;
    chk("spawn_en", bus.wr_en, 1);
    chk("spawn_idx", bus.wr_index, idx);
    chk("spawn_pos", bus.wr_position, {x, y});
    chk("spawn_render", bus.wr_render, 1);
    chk("spawn_count", active_count, cnt);
  endtask

  // One tick then eight slot cycles; writes are captured per slot index
  task automatic sweep();
    for (int i = 0; i < 8; i++) begin
      rec_en[i] = 1'b0; rec_pos[i] = '0; rec_ren[i] = 1'b0;
    end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("sweep_done", update_done, (k == 8));
      if (bus.wr_en) begin
        chk("sweep_idx", bus.wr_index, k - 1);
        rec_en[bus.wr_index]  = 1'b1;
        rec_pos[bus.wr_index] = bus.wr_position;
        rec_ren[bus.wr_index] = bus.wr_render;
      end
    end
  endtask

  task automatic clear_seq();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("clr_en", bus.wr_en, 1);
      chk("clr_idx", bus.wr_index, i);
      chk("clr_render", bus.wr_render, 0);
      chk("clr_pos", bus.wr_position, 0);
    end
    chk("clr_busy", busy, 0);
    chk("clr_count", active_count, 0);
  endtask

  initial begin
    int d1, d2, nd;
    reset = 1'b1; frame_tick = 1'b0;
    bus.spawn_valid = 1'b0; bus.spawn_x = '0; bus.spawn_y = '0; bus.spawn_dx = '0;
    bus.spawn_dy = '0; bus.spawn_w = '0; bus.spawn_h = '0; bus.spawn_color = '0;
    repeat (3) step();
    chk("rst_busy", busy, 1);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_count", active_count, 0);
    chk("rst_ready", bus.spawn_ready, 0);
    chk("rst_ovr", tick_overrun, 0);
    chk("rst_done", update_done, 0);

    reset = 1'b0;
    clear_seq();
    chk("idle_ready", bus.spawn_ready, 1);

    // x=10 y=20 dx=+3 dy=-2 colour 5
    spawn(8'd10, 8'd20, 4'h3, 4'hE, 3'd5, 0, 1);
    chk("spawn0_pos", bus.wr_position, 16'h0A14);
    chk("spawn0_size", bus.wr_size, 16'h0404);
    chk("spawn0_color", bus.wr_color, 5);
    step();
    chk("spawn0_once", bus.wr_en, 0);

    sweep();
    chk("mv0_en", rec_en[0], 1);
    chk("mv0_pos", rec_pos[0], 16'h0D12);
    chk("mv0_render", rec_ren[0], 1);
    chk("mv_inactive", rec_en[1], 0);
    chk("mv_idle", busy, 0);

    // Right-edge exit: 254 + 3 overflows
    spawn(8'd254, 8'd50, 4'h3, 4'h0, 3'd1, 1, 2);
    sweep();
    chk("ex0_pos", rec_pos[0], 16'h1010);
    chk("ex1_en", rec_en[1], 1);
    chk("ex1_render", rec_ren[1], 0);
    chk("ex1_pos", rec_pos[1], 16'hFE32);
    chk("ex_count", active_count, 1);

    // Fill the table; slot 3 exits right, slot 7 exits through y=0
    spawn(8'd100, 8'd100, 4'h0, 4'h0, 3'd2, 1, 2);
    spawn(8'd40,  8'd40,  4'h0, 4'h0, 3'd2, 2, 3);
    spawn(8'd253, 8'd60,  4'h3, 4'h0, 3'd2, 3, 4);
    spawn(8'd80,  8'd80,  4'h0, 4'h0, 3'd2, 4, 5);
    spawn(8'd90,  8'd90,  4'h0, 4'h0, 3'd2, 5, 6);
    spawn(8'd5,   8'd5,   4'hF, 4'hF, 3'd2, 6, 7);
    spawn(8'd7,   8'd0,   4'h0, 4'hF, 3'd2, 7, 8);
    chk("full_ready", bus.spawn_ready, 0);
    bus.spawn_valid = 1'b1;
    step();
    bus.spawn_valid = 1'b0;
    chk("full_no_wr", bus.wr_en, 0);
    chk("full_count", active_count, 8);

    sweep();
    chk("f0_pos", rec_pos[0], 16'h130E);
    chk("f1_static", rec_pos[1], 16'h6464);
    chk("f1_render", rec_ren[1], 1);
    chk("f3_render", rec_ren[3], 0);
    chk("f3_pos", rec_pos[3], 16'hFD3C);
    chk("f5_static", rec_pos[5], 16'h5A5A);
    chk("f6_pos", rec_pos[6], 16'h0404);
    chk("f7_render", rec_ren[7], 0);
    chk("f7_pos", rec_pos[7], 16'h0700);
    chk("f_count", active_count, 6);
    spawn(8'd30, 8'd30, 4'h0, 4'h0, 3'd3, 3, 7);

    // Ticks two cycles apart: one queued, one dropped
    frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    chk("ovr_set", tick_overrun, 1);
    d1 = -1; d2 = -1; nd = 0;
    for (int n = 5; n < 30; n++) begin
      step();
      if (update_done) begin
        nd++;
        if (d1 < 0) d1 = n; else if (d2 < 0) d2 = n;
      end
    end
    chk("ovr_first_done", d1, 8);
    chk("ovr_second_done", d2, 17);
    chk("ovr_sweeps", nd, 2);
    chk("ovr_sticky", tick_overrun, 1);

    // Reset while slot 4 is about to be processed
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    repeat (4) step();
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    step();
    chk("mid_rst_wr", bus.wr_en, 0);
    chk("mid_rst_count", active_count, 0);
    chk("mid_rst_ovr", tick_overrun, 0);
    chk("mid_rst_busy", busy, 1);
    step();
    chk("mid_rst_wr2", bus.wr_en, 0);
    reset = 1'b0;
    clear_seq();
    nd = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (update_done || bus.wr_en) nd++;
    end
    chk("post_rst_quiet", nd, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
